// File: rtl/ff_ctrl_pkg.sv
// Shared definitions for the flip-flop conversion self-test controller.
//   - ctrl_state_e   : controller FSM states
//   - Lfsr*          : LFSR width and feedback taps (x^8 feedback from bits 7,5,4,3)
//   - Lane*          : lane index constants into the 3-bit lane Q vector
//   - sanitise_seed  : maps an all-zero seed to 8'h01 so the LFSR can never lock up
//   - lfsr_step      : one left-shift step of the LFSR
package ff_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPrime,
      StRun,
      StCheck,
      StDone,
      StFail
   } ctrl_state_e;

   localparam int unsigned LfsrWidth = 8;
   localparam logic [LfsrWidth-1:0] LfsrTaps = 8'b1011_1000;

   localparam int unsigned NumLanes = 3;
   localparam int unsigned LaneSr   = 0;
   localparam int unsigned LaneJk   = 1;
   localparam int unsigned LaneT    = 2;

   function automatic logic [LfsrWidth-1:0] sanitise_seed(input logic [LfsrWidth-1:0] seed);
      return (seed == '0) ? {{(LfsrWidth-1){1'b0}}, 1'b1} : seed;
   endfunction

   function automatic logic [LfsrWidth-1:0] lfsr_step(input logic [LfsrWidth-1:0] cur);
      return {cur[LfsrWidth-2:0], ^(cur & LfsrTaps)};
   endfunction

endpackage

// File: rtl/ff_conv_lanes.sv
// Three D-equivalent flip-flop lanes built from other flip-flop types.
//   SR lane : S = D, R = ~D
//   JK lane : J = D, K = ~D
//   T lane  : T = D ^ Q
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, clears all lanes
//   clr_i   : synchronous clear of all lanes (wins over en_i)
//   en_i    : capture enable; lanes hold when low
//   d_i     : common D input
//   q_o     : lane outputs, indexed by LaneSr/LaneJk/LaneT
module ff_conv_lanes
   import ff_ctrl_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clr_i,
   input  logic                en_i,
   input  logic                d_i,
   output logic [NumLanes-1:0] q_o
);

   logic [NumLanes-1:0] q_q, q_d;
   logic s, r, j, k, t;

   always_comb begin
      s = d_i;
      r = ~d_i;
      j = d_i;
      k = ~d_i;
      t = d_i ^ q_q[LaneT];

      q_d = q_q;
      // Characteristic equations of each flip-flop type.
      q_d[LaneSr] = s | (~r & q_q[LaneSr]);
      q_d[LaneJk] = (j & ~q_q[LaneJk]) | (~k & q_q[LaneJk]);
      q_d[LaneT]  = q_q[LaneT] ^ t;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= '0;
      end else if (clr_i) begin
         q_q <= '0;
      end else if (en_i) begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/ff_conv_selftest_ctrl.sv
// Bring-up / BIST controller for the D-equivalent flip-flop lanes.
// On start it clears the lanes, drives N_VECTORS vectors (LFSR bit 0 or d_ext_i) into
// all three lanes and a golden D register, and compares every lane against golden
// one cycle after each drive. Reports pass, or the first failing vector and lane mask.
// Ports:
//   clk_i, rst_ni      : clock (rising edge), asynchronous active-low reset
//   start_i            : start pulse, accepted in idle/done/fail only
//   abort_i            : return to idle from any busy state
//   use_ext_i, d_ext_i : D source select (latched at start) and external D
//   fault_inj_i        : per-lane XOR into the compare path (bit0 SR, bit1 JK, bit2 T)
//   busy_o, done_o     : run in progress / result available
//   pass_o             : run completed without mismatch
//   fail_idx_o         : first mismatching vector index
//   fail_mask_o        : lanes mismatching at fail_idx_o
//   d_drive_o          : D currently presented to the lanes
//   q_sr_o/q_jk_o/q_t_o: raw lane outputs
module ff_conv_selftest_ctrl
   import ff_ctrl_pkg::*;
#(
   parameter int unsigned    N_VECTORS = 64,
   parameter logic [7:0]     LFSR_SEED = 8'hA5
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic       abort_i,
   input  logic       use_ext_i,
   input  logic       d_ext_i,
   input  logic [2:0] fault_inj_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       pass_o,
   output logic [7:0] fail_idx_o,
   output logic [2:0] fail_mask_o,
   output logic       d_drive_o,
   output logic       q_sr_o,
   output logic       q_jk_o,
   output logic       q_t_o
);

   localparam logic [LfsrWidth-1:0] SeedSafe = sanitise_seed(LFSR_SEED);
   localparam logic [7:0]           LastIdx  = 8'(N_VECTORS - 1);

   ctrl_state_e          state_q, state_d;
   logic [LfsrWidth-1:0] lfsr_q, lfsr_d;
   logic [7:0]           count_q, count_d;
   logic                 golden_q, golden_d;
   logic                 use_ext_q, use_ext_d;
   logic                 pass_q, pass_d;
   logic [7:0]           fail_idx_q, fail_idx_d;
   logic [2:0]           fail_mask_q, fail_mask_d;

   logic                lane_clr, lane_en;
   logic                d_sel, d_drive;
   logic [NumLanes-1:0] lane_q;
   logic                cmp_active;
   logic [NumLanes-1:0] mismatch;

   ff_conv_lanes u_lanes (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (lane_clr),
      .en_i   (lane_en),
      .d_i    (d_drive),
      .q_o    (lane_q)
   );

   assign d_sel = use_ext_q ? d_ext_i : lfsr_q[0];

   // The first RUN cycle has nothing captured yet; afterwards count_q-1 is the vector
   // sitting in the lanes. In CHECK the last vector is compared.
   assign cmp_active = ((state_q == StRun) && (count_q != 8'd0)) || (state_q == StCheck);
   assign mismatch   = cmp_active ? ((lane_q ^ fault_inj_i) ^ {NumLanes{golden_q}}) : '0;

   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      count_d     = count_q;
      golden_d    = golden_q;
      use_ext_d   = use_ext_q;
      pass_d      = pass_q;
      fail_idx_d  = fail_idx_q;
      fail_mask_d = fail_mask_q;
      lane_clr    = 1'b0;
      lane_en     = 1'b0;
      d_drive     = 1'b0;

      case (state_q)
         StIdle, StDone, StFail: begin
            if (start_i) begin
               state_d     = StPrime;
               use_ext_d   = use_ext_i;
               pass_d      = 1'b0;
               fail_idx_d  = '0;
               fail_mask_d = '0;
            end
         end

         StPrime: begin
            if (abort_i) begin
               state_d     = StIdle;
               pass_d      = 1'b0;
               fail_idx_d  = '0;
               fail_mask_d = '0;
            end else begin
               state_d  = StRun;
               lane_clr = 1'b1;
               golden_d = 1'b0;
               lfsr_d   = SeedSafe;
               count_d  = '0;
            end
         end

         StRun: begin
            d_drive = d_sel;
            if (abort_i) begin
               state_d     = StIdle;
               pass_d      = 1'b0;
               fail_idx_d  = '0;
               fail_mask_d = '0;
            end else if (|mismatch) begin
               // Lanes freeze on the failing vector for post-mortem inspection.
               state_d     = StFail;
               fail_idx_d  = count_q - 8'd1;
               fail_mask_d = mismatch;
            end else begin
               lane_en  = 1'b1;
               golden_d = d_sel;
               lfsr_d   = lfsr_step(lfsr_q);
               count_d  = count_q + 8'd1;
               if (count_q == LastIdx) begin
                  state_d = StCheck;
               end
            end
         end

         StCheck: begin
            if (abort_i) begin
               state_d     = StIdle;
               pass_d      = 1'b0;
               fail_idx_d  = '0;
               fail_mask_d = '0;
            end else if (|mismatch) begin
               state_d     = StFail;
               fail_idx_d  = count_q - 8'd1;
               fail_mask_d = mismatch;
            end else begin
               state_d = StDone;
               pass_d  = 1'b1;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         lfsr_q      <= SeedSafe;
         count_q     <= '0;
         golden_q    <= 1'b0;
         use_ext_q   <= 1'b0;
         pass_q      <= 1'b0;
         fail_idx_q  <= '0;
         fail_mask_q <= '0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         count_q     <= count_d;
         golden_q    <= golden_d;
         use_ext_q   <= use_ext_d;
         pass_q      <= pass_d;
         fail_idx_q  <= fail_idx_d;
         fail_mask_q <= fail_mask_d;
      end
   end

   assign busy_o      = (state_q == StPrime) || (state_q == StRun) || (state_q == StCheck);
   assign done_o      = (state_q == StDone) || (state_q == StFail);
   assign pass_o      = pass_q;
   assign fail_idx_o  = fail_idx_q;
   assign fail_mask_o = fail_mask_q;
   assign d_drive_o   = d_drive;
   assign q_sr_o      = lane_q[LaneSr];
   assign q_jk_o      = lane_q[LaneJk];
   assign q_t_o       = lane_q[LaneT];

endmodule

// File: tb/tb_ff_conv_selftest_ctrl.sv
// Self-checking bench for ff_conv_selftest_ctrl: randomized D sources and fault masks
// checked against a cycle-level reference of the run sequence.
module tb_ff_conv_selftest_ctrl;

   localparam int         N    = 64;
   localparam logic [7:0] SEED = 8'hA5;

   logic       clk;
   logic       rst_n;
   logic       start, abort, use_ext, d_ext;
   logic [2:0] fault_inj;
   logic       busy, done, pass, d_drive, q_sr, q_jk, q_t;
   logic [7:0] fail_idx;
   logic [2:0] fail_mask;

   int n_checks = 0;
   int n_errors = 0;

   ff_conv_selftest_ctrl #(
      .N_VECTORS (N),
      .LFSR_SEED (SEED)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .abort_i     (abort),
      .use_ext_i   (use_ext),
      .d_ext_i     (d_ext),
      .fault_inj_i (fault_inj),
      .busy_o      (busy),
      .done_o      (done),
      .pass_o      (pass),
      .fail_idx_o  (fail_idx),
      .fail_mask_o (fail_mask),
      .d_drive_o   (d_drive),
      .q_sr_o      (q_sr),
      .q_jk_o      (q_jk),
      .q_t_o       (q_t)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference LFSR: shift left, new bit 0 = b7^b5^b4^b3.
   function automatic logic [7:0] ref_lfsr_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   function automatic logic [2:0] lanes();
      return {q_t, q_jk, q_sr};
   endfunction

   // One full run. Every lane behaves as a plain D flip-flop, so with fault injection the
   // mismatch mask equals fi at the very first compare (vector 0).
   task automatic run_vectors(input bit ext, input logic [2:0] fi, input bit poke);
      logic [7:0] lfsr;
      logic       dexp, dprev, d0;
      int         busy_cycles;
      @(negedge clk);
      start = 1'b1; use_ext = ext; fault_inj = fi;
      @(negedge clk);
      start = 1'b0; use_ext = 1'($urandom);
      #1;
      check_val("prime_busy", busy, 1);
      check_val("prime_done", done, 0);
      check_val("prime_pass", pass, 0);
      check_val("prime_drive", d_drive, 0);
      busy_cycles = busy ? 1 : 0;
      lfsr = SEED; dprev = 1'b0; d0 = 1'b0;
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         start = poke && (k == 8);
         d_ext = 1'($urandom);
         #1;
         if (fi != 3'b000 && k == 2) begin
            check_val("fail_done", done, 1);
            check_val("fail_pass", pass, 0);
            check_val("fail_busy", busy, 0);
            check_val("fail_idx", fail_idx, 0);
            check_val("fail_mask", fail_mask, fi);
            check_val("fail_lanes_frozen", lanes(), {3{d0}});
            return;
         end
         dexp = ext ? d_ext : lfsr[0];
         if (busy) busy_cycles++;
         check_val("run_busy", busy, 1);
         check_val("run_drive", d_drive, dexp);
         check_val("run_lanes", lanes(), {3{dprev}});
         if (k == 0) d0 = dexp;
         dprev = dexp;
         lfsr  = ref_lfsr_next(lfsr);
      end
      start = 1'b0;
      @(negedge clk); #1;
      if (busy) busy_cycles++;
      check_val("check_busy", busy, 1);
      check_val("check_done", done, 0);
      check_val("check_lanes", lanes(), {3{dprev}});
      @(negedge clk); #1;
      check_val("end_done", done, 1);
      check_val("end_pass", pass, 1);
      check_val("end_busy", busy, 0);
      check_val("end_mask", fail_mask, 0);
      check_val("end_lanes", lanes(), {3{dprev}});
      check_val("busy_cycles", busy_cycles, N + 2);
   endtask

   task automatic abort_run();
      @(negedge clk);
      start = 1'b1; use_ext = 1'b0; fault_inj = 3'b000;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 11; i++) @(negedge clk);
      #1;
      check_val("pre_abort_busy", busy, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      check_val("abort_busy", busy, 0);
      check_val("abort_done", done, 0);
      check_val("abort_pass", pass, 0);
      check_val("abort_mask", fail_mask, 0);
      check_val("abort_idx", fail_idx, 0);
   endtask

   task automatic reset_run();
      @(negedge clk);
      start = 1'b1; use_ext = 1'b0; fault_inj = 3'b000;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 7; i++) @(negedge clk);
      #1;
      check_val("pre_reset_busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_pass", pass, 0);
      check_val("rst_idx", fail_idx, 0);
      check_val("rst_mask", fail_mask, 0);
      check_val("rst_drive", d_drive, 0);
      check_val("rst_lanes", lanes(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_val("post_rst_busy", busy, 0);
      check_val("post_rst_done", done, 0);
   endtask

   initial begin
      rst_n = 1'b1; start = 1'b0; abort = 1'b0; use_ext = 1'b0; d_ext = 1'b0;
      fault_inj = 3'b000;
      #2 rst_n = 1'b0;
      #1;
      check_val("reset_busy", busy, 0);
      check_val("reset_done", done, 0);
      check_val("reset_pass", pass, 0);
      check_val("reset_idx", fail_idx, 0);
      check_val("reset_mask", fail_mask, 0);
      check_val("reset_drive", d_drive, 0);
      check_val("reset_lanes", lanes(), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_vectors(1'b0, 3'b000, 1'b0);   // clean LFSR run
      run_vectors(1'b0, 3'b100, 1'b0);   // stuck T lane
      run_vectors(1'b0, 3'b000, 1'b1);   // restart from FAIL, start poked while busy
      run_vectors(1'b1, 3'b000, 1'b0);   // external D source
      abort_run();
      run_vectors(1'b0, 3'b000, 1'b0);
      for (int r = 0; r < 6; r++) begin
         run_vectors(1'($urandom), 3'($urandom), 1'($urandom));
      end
      reset_run();
      run_vectors(1'b1, 3'b000, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ff_conv_selftest_ctrl.md
# ff_conv_selftest_ctrl

Sequencer and self-check controller for the D-equivalent flip-flop lanes: the SR-based lane (S=D, R=~D), the JK-based lane (J=D, K=~D) and the T-based lane (T=D^Q). On `start` it clears the lanes, then drives N pseudo-random or external D vectors into all three. It compares each lane against a golden D register and reports pass/fail with the first failing vector index and lane mask. It sits beside the lane datapath as its bring-up and BIST controller.

## Interface
- `N_VECTORS`, 64: vectors per run, 1..255.
- `LFSR_SEED`, 8'hA5: LFSR start value; 8'h00 is replaced by 8'h01.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserts immediately, releases on clock).
- `start` in 1: one-cycle pulse; accepted only in IDLE, DONE or FAIL.
- `abort` in 1: returns to IDLE from any busy state.
- `use_ext` in 1: 1 = D comes from `d_ext`; 0 = D comes from LFSR bit 0. Sampled at start accept.
- `d_ext` in 1: external D source.
- `fault_inj` in 3: per-lane XOR into the compare path, bit0=SR, bit1=JK, bit2=T. Test only.
- `busy` out 1: high in PRIME, RUN and CHECK.
- `done` out 1: high in DONE and FAIL.
- `pass` out 1: high only in DONE.
- `fail_idx` out 8: index of the first mismatching vector.
- `fail_mask` out 3: lanes mismatching at `fail_idx`.
- `d_drive` out 1: D currently presented to the lanes.
- `q_sr`, `q_jk`, `q_t` out 1 each: lane outputs, uncorrupted by `fault_inj`.

## Operation
- States are IDLE, PRIME, RUN, CHECK, DONE and FAIL.
- **Reset:** state=IDLE, LFSR=seed, vector count=0, golden=0, all lanes Q=0. All outputs are 0.
- **IDLE/DONE/FAIL + `start`:** go to PRIME. Latch `use_ext`. Clear `fail_idx`, `fail_mask` and `pass`.
- **PRIME (1 cycle):** synchronous clear of the lanes and golden; reload LFSR=seed; count=0; `d_drive`=0. Then go to RUN.
- **RUN, each cycle:**
  - `d_drive` = selected source.
  - Lanes and golden capture `d_drive` at the edge.
  - The LFSR advances one step: shift left, bit0 = b7^b5^b4^b3.
  - The count increments.
  - When the count reaches N_VECTORS-1 on a drive, go to CHECK.
- **Compare:** active in every RUN cycle after the first, and in CHECK.
  - mismatch[i] = (lane_q[i] ^ fault_inj[i]) != golden.
  - The compare applies to vector index count-1.
- **Any mismatch:** latch `fail_idx` = index of the vector being compared and `fail_mask` = mismatch bits. Go to FAIL. Lanes stop receiving new vectors.
- **CHECK (1 cycle):** final compare. On no mismatch go to DONE with `pass`=1.
- **DONE/FAIL:** hold results until the next `start` or reset.
- **`abort` in PRIME/RUN/CHECK:** go to IDLE; clear `pass`, `fail_idx` and `fail_mask`.
  - `abort` has priority over mismatch and count-complete in the same cycle.
  - `abort` in IDLE/DONE/FAIL is ignored.
- **Simultaneous `start` and `abort` in DONE:** `start` wins.
- **`start` while busy:** ignored.
- **LFSR:** never reaches 0 (nonzero seed enforced). It wraps after 255 steps.
- **T lane:** its correctness depends on feedback from its own Q, so it must clear in PRIME together with the other lanes.

## Timing
- Take the start accept edge as edge 0:
  - PRIME occupies cycle 1.
  - RUN occupies cycles 2..N+1.
  - CHECK occupies cycle N+2.
  - `done` rises after edge N+2.
- `busy` is high for exactly N+2 cycles.
- Compare latency is 1 cycle: vector k, driven in cycle k+2, is checked in cycle k+3.
- A FAIL transition occurs at the edge ending the cycle in which the mismatch is seen. `fail_idx`/`fail_mask` are valid with `done`.
- `reset` low takes effect immediately in any state, including mid-run. It is not a graceful stop.

## Structure
- Shared package `ff_ctrl_pkg`, holding:
  - the state enum;
  - LFSR width and tap constants;
  - the seed-sanitise function (0 becomes 1);
  - the lane index constants SR=0, JK=1, T=2.
- One sub-module, `ff_conv_lanes`. It contains the three lanes with a common clk, reset and sync clear, and outputs a 3-bit Q vector.
- The controller holds the FSM, LFSR, counter, golden register and comparator.

## Test plan
- **Clean LFSR run:** N=64, seed A5, `use_ext`=0, `fault_inj`=0, `start` pulse. Required: `busy` high for 66 cycles, then `done`=1, `pass`=1, `fail_mask`=0.
- **Stuck T lane:** `fault_inj`=3'b100. Required: FAIL, `fail_idx`=0, `fail_mask`=3'b100, `pass`=0, `done` one cycle after the first compare.
- **External D source:** `use_ext`=1, `d_ext` toggling 1,0,1,0, N=4. Required: `d_drive` follows `d_ext`; after each drive all lanes equal the driven value; `pass`=1.
- **Abort mid-run:** assert `abort` in RUN cycle 10. Required: IDLE next cycle, with `busy`, `done` and `pass` all 0. A subsequent `start` then completes normally with `pass`=1.
- **Reset mid-run:** `reset` low in RUN. Required: all outputs and lane Q drop to 0 immediately. After release the block sits in IDLE until `start`.
- **Start while busy, and restart from FAIL:** a `start` pulse during RUN leaves the timing unchanged. `start` in FAIL with `fault_inj`=0 yields `pass`=1 and cleared `fail_mask`.
